mux2_arbiter: RTL
=================

Name: mux2_arbiter

Overview:
- Round-robin arbiter that shares one registered 2:1 mux datapath between two requesters, A and B.
- Sequences ownership and drives the mux select line.
- Registers the selected data to the output with a valid flag.
- Bounds each owner's tenure with a hold counter so neither requester can starve the other.

Parameters:
DATA_W, 1, width of each data input and of the output
MAX_HOLD, 8, maximum consecutive cycles one owner keeps the mux while the other requester waits (legal range 1..255)

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
req_a  input  1  requester A wants the mux; level, held while it needs access
req_b  input  1  requester B wants the mux; level
a  input  DATA_W  requester A data
b  input  DATA_W  requester B data
gnt_a  output  1  A owns the mux this cycle
gnt_b  output  1  B owns the mux this cycle
slt_line  output  1  mux select; 0 = a, 1 = b
out  output  DATA_W  registered mux output
out_valid  output  1  out holds data captured during a grant cycle

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE; gnt_a=gnt_b=0; slt_line=0; out=0; out_valid=0; hold_cnt=0; last_owner=B (A wins the first tie).
  - Reset mid-tenure drops the grant immediately, with no completion of the in-flight cycle.
- States: IDLE, OWN_A, OWN_B. gnt_a=(state==OWN_A); gnt_b=(state==OWN_B). Both grants are registered and never high together.
- slt_line is registered: 0 in OWN_A, 1 in OWN_B. In IDLE it holds its last value.
- IDLE transitions, evaluated on the sampled requests:
  - req_a only -> OWN_A.
  - req_b only -> OWN_B.
  - Both -> the requester that is not last_owner.
  - Neither -> stay IDLE.
  - Grant latency: request high at edge N gives grant high after edge N+1's update (one cycle).
- OWN_X (X in {A,B}, Y the other requester), per cycle:
  - req_X low and req_Y high -> OWN_Y directly, with no idle bubble.
  - req_X low and req_Y low -> IDLE.
  - req_X high, req_Y high, hold_cnt == MAX_HOLD-1 -> forced switch to OWN_Y.
  - Otherwise -> stay in OWN_X.
- hold_cnt:
  - Cleared on every entry into an OWN state.
  - Increments each cycle in an OWN state while the other requester's req is high.
  - Saturates at MAX_HOLD-1.
  - Cleared while the other req is low, so a lone owner keeps the mux indefinitely.
- last_owner updates to X on entry into OWN_X.
- Datapath, registered one cycle behind grant:
  - out <= slt_line ? b : a, using the current registered slt_line.
  - out_valid <= gnt_a | gnt_b.
  - Data captured in cycle N appears at out in cycle N+1.
  - When out_valid is 0, out holds its previous value.
- Simultaneous events:
  - Owner drops req on the same cycle the counter expires -> handled by the drop rule; the result is the same OWN_Y.
  - A requester reasserting the cycle after its release waits for normal arbitration.
- MAX_HOLD=1: tenure is one cycle under contention; strict alternation.

Test Plan:
- Reset: assert rst_n=0 mid-run while OWN_B -> same-cycle gnt_b=0, slt_line=0, out=0, out_valid=0. Release with req_a=req_b=1 -> gnt_a=1 one cycle later.
- Single requester: req_a=1 alone for 20 cycles, a=1 -> gnt_a=1 for all cycles, no timeout. out=1 with out_valid=1 from the cycle after the first grant. Drop req_a -> IDLE next cycle, out_valid=0 one cycle later.
- Handoff without bubble: OWN_A, then req_a=0 with req_b=1 on the same edge -> next cycle gnt_b=1, slt_line=1, no cycle with both grants at 0. out follows b (b=0 gives out=0) one cycle later.
- Fairness timeout: MAX_HOLD=8, req_a=req_b=1 held continuously -> grants alternate exactly 8 cycles A, 8 cycles B, repeating. Never both grants high.
- Tie after idle: last owner B, then both requests rise together from IDLE -> gnt_a wins. Repeat with last owner A -> gnt_b wins.
- Datapath check: a=0, b=1 with grants alternating per the fairness test -> out switches 0/1 exactly one cycle after each slt_line change, out_valid stays 1 throughout.

Source files
------------

// File: rtl/mux2_arbiter_if.sv
// mux2_arbiter_if: request/grant and data bundle for the shared 2:1 mux.
//   req_a, req_b   : level requests from requesters A and B
//   a, b           : requester data (DATA_W bits)
//   gnt_a, gnt_b   : registered one-hot grants (never both high)
//   slt_line       : registered mux select, 0 = a, 1 = b
//   out, out_valid : registered mux output and its valid flag
// master modport: requester/environment side; slave modport: arbiter side.
interface mux2_arbiter_if #(
  parameter int DATA_W = 1
);
  logic              req_a;
  logic              req_b;
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic              gnt_a;
  logic              gnt_b;
  logic              slt_line;
  logic [DATA_W-1:0] out;
  logic              out_valid;

  modport master (
    output req_a, req_b, a, b,
    input  gnt_a, gnt_b, slt_line, out, out_valid
  );

  modport slave (
    input  req_a, req_b, a, b,
    output gnt_a, gnt_b, slt_line, out, out_valid
  );
endinterface

// File: rtl/mux2_arbiter.sv
// mux2_arbiter: round-robin arbiter sharing one registered 2:1 mux between
// requesters A and B. Each owner's tenure under contention is bounded to
// MAX_HOLD cycles; a lone owner keeps the mux indefinitely.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : mux2_arbiter_if.slave (requests, data, grants, select, output)
module mux2_arbiter #(
  parameter int DATA_W   = 1,
  parameter int MAX_HOLD = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  mux2_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_A = 2'd1,
    OWN_B = 2'd2
  } state_t;

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  state_t            state, state_nxt;
  logic [7:0]        hold_cnt, hold_nxt;
  logic              last_is_b;
  logic              contended;
  logic              gnt_a_q, gnt_b_q, slt_q, valid_q;
  logic [DATA_W-1:0] out_q;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (bus.req_a && bus.req_b) state_nxt = last_is_b ? OWN_A : OWN_B;
        else if (bus.req_a)         state_nxt = OWN_A;
        else if (bus.req_b)         state_nxt = OWN_B;
      end
      OWN_A: begin
        if (!bus.req_a)                            state_nxt = bus.req_b ? OWN_B : IDLE;
        else if (bus.req_b && hold_cnt == HOLD_LAST) state_nxt = OWN_B;
      end
      OWN_B: begin
        if (!bus.req_b)                            state_nxt = bus.req_a ? OWN_A : IDLE;
        else if (bus.req_a && hold_cnt == HOLD_LAST) state_nxt = OWN_A;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // The counter only runs while the other side is waiting, so an
  // uncontested owner never times out.
  always_comb begin
    contended = ((state == OWN_A) && bus.req_b) || ((state == OWN_B) && bus.req_a);
    hold_nxt  = '0;
    if ((state_nxt != IDLE) && (state_nxt != state)) hold_nxt = '0;
    else if (contended)
      hold_nxt = (hold_cnt == HOLD_LAST) ? hold_cnt : hold_cnt + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      hold_cnt  <= '0;
      last_is_b <= 1'b1;
      gnt_a_q   <= 1'b0;
      gnt_b_q   <= 1'b0;
      slt_q     <= 1'b0;
    end else begin
      state    <= state_nxt;
      hold_cnt <= hold_nxt;
      gnt_a_q  <= (state_nxt == OWN_A);
      gnt_b_q  <= (state_nxt == OWN_B);
      if (state_nxt == OWN_A) begin
        slt_q     <= 1'b0;
        last_is_b <= 1'b0;
      end else if (state_nxt == OWN_B) begin
        slt_q     <= 1'b1;
        last_is_b <= 1'b1;
      end
    end
  end

  // Datapath lags the grant by one cycle; out holds while nobody owns the mux.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= gnt_a_q | gnt_b_q;
      if (gnt_a_q | gnt_b_q) out_q <= slt_q ? bus.b : bus.a;
    end
  end

  assign bus.gnt_a     = gnt_a_q;
  assign bus.gnt_b     = gnt_b_q;
  assign bus.slt_line  = slt_q;
  assign bus.out       = out_q;
  assign bus.out_valid = valid_q;

endmodule
